// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for a conv/maxpool pipeline: streams one frame of pixels out of
// frame memory, then waits for the pipeline's output counts to finish the frame.
module conv_frame_sequencer #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int ROW_SIZE      = 28,
  parameter int COLUMN_SIZE   = 28,
  parameter int KERNEL_SIZE1  = 3,
  parameter int KERNEL_SIZE2  = 2,
  parameter int ADDR_W        = 10,
  parameter int CNT_W         = 10,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pause,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [IN_DATA_WIDTH-1:0] mem_data,
  output logic [IN_DATA_WIDTH-1:0] pixel_out,
  output logic                     pixel_valid,
  input  logic                     con_valid_in,
  input  logic                     max_valid_in,
  output logic [CNT_W-1:0]         con_count,
  output logic [CNT_W-1:0]         max_count,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int N_PIX   = ROW_SIZE * COLUMN_SIZE;
  localparam int N_CON   = (ROW_SIZE - KERNEL_SIZE1 + 1) * (COLUMN_SIZE - KERNEL_SIZE1 + 1);
  localparam int N_MAX   = N_CON / (KERNEL_SIZE2 * KERNEL_SIZE2);
  localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]     con_count_q, con_count_d;
  logic [CNT_W-1:0]     max_count_q, max_count_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 error_q, error_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pixel_valid_q;
  logic                 rd_en;

  assign rd_en       = (state_q == S_FEED) && !pause;
  assign mem_rd_en   = rd_en;
  assign mem_addr    = addr_q;
  assign pixel_out   = mem_data;
  assign pixel_valid = pixel_valid_q;
  assign con_count   = con_count_q;
  assign max_count   = max_count_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    con_count_d = con_count_q;
    max_count_d = max_count_q;
    drain_d     = drain_q;
    error_d     = error_q;

    // Pipeline outputs are tallied only while a frame is in flight; counts saturate
    // at the frame target and any extra valid is flagged as a fault.
    if (state_q == S_FEED || state_q == S_DRAIN) begin
      if (con_valid_in) begin
        if (con_count_q == CNT_W'(N_CON)) error_d = 1'b1;
        else                              con_count_d = con_count_q + CNT_W'(1);
      end
      if (max_valid_in) begin
        if (max_count_q == CNT_W'(N_MAX)) error_d = 1'b1;
        else                              max_count_d = max_count_q + CNT_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FEED;
          addr_d      = '0;
          con_count_d = '0;
          max_count_d = '0;
          error_d     = 1'b0;
        end
      end
      S_FEED: begin
        drain_d = '0;
        if (rd_en) begin
          if (addr_q == ADDR_W'(N_PIX - 1)) state_d = S_DRAIN;
          else                              addr_d  = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (con_count_d == CNT_W'(N_CON) && max_count_d == CNT_W'(N_MAX)) begin
          state_d = S_DONE;
        end else if (drain_q == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FEED) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      con_count_q   <= '0;
      max_count_q   <= '0;
      drain_q       <= '0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      con_count_q   <= con_count_d;
      max_count_q   <= max_count_d;
      drain_q       <= drain_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pixel_valid_q <= rd_en;
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer with a simple pipeline model that
// returns convolution/maxpool valids once enough pixels have been streamed.
module tb_conv_frame_sequencer;

  logic       clock;
  logic       reset;
  logic       start;
  logic       pause;
  logic       mem_rd_en;
  logic [9:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] pixel_out;
  logic       pixel_valid;
  logic       con_valid_in;
  logic       max_valid_in;
  logic [9:0] con_count;
  logic [9:0] max_count;
  logic       busy;
  logic       done;
  logic       error;

  conv_frame_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .con_valid_in(con_valid_in),
    .max_valid_in(max_valid_in),
    .con_count   (con_count),
    .max_count   (max_count),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Frame control written by the main sequence, read by the monitor.
  int frame_id   = 0;
  int con_target = 0;
  int max_target = 0;

  // Monitor / pipeline-model state, written only by the monitor.
  int seen_id  = 0;
  int rd_cnt, addr_bad, pv_bad, done_cnt, busy_cyc, pause_cyc, pix_bad;
  int pv_seen, cons_sent, maxs_sent;
  logic prev_rd, prev_rst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Memory returns a data pattern derived from the address read last cycle.
  logic [9:0] last_addr;
  always @(posedge clock) last_addr <= mem_addr;
  assign mem_data = last_addr[7:0] ^ 8'h5A;

  initial begin
    con_valid_in = 1'b0;
    max_valid_in = 1'b0;
    rd_cnt = 0; addr_bad = 0; pv_bad = 0; done_cnt = 0; busy_cyc = 0; pause_cyc = 0;
    pix_bad = 0; pv_seen = 0; cons_sent = 0; maxs_sent = 0;
    prev_rd = 1'b0; prev_rst = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (frame_id != seen_id) begin
        seen_id = frame_id;
        rd_cnt = 0; addr_bad = 0; pv_bad = 0; done_cnt = 0; busy_cyc = 0; pause_cyc = 0;
        pix_bad = 0; pv_seen = 0; cons_sent = 0; maxs_sent = 0;
        prev_rd = 1'b0;
      end
      if (mem_rd_en) begin
        if (int'(mem_addr) != rd_cnt) addr_bad++;
        rd_cnt++;
      end
      if (pixel_valid !== (prev_rd & ~prev_rst)) pv_bad++;
      if (pixel_valid && pixel_out !== mem_data) pix_bad++;
      prev_rd  = mem_rd_en;
      prev_rst = reset;
      if (done) done_cnt++;
      if (busy) busy_cyc++;
      if (busy && !mem_rd_en && rd_cnt < 784) pause_cyc++;
      if (pixel_valid) pv_seen++;
      con_valid_in = 1'b0;
      max_valid_in = 1'b0;
      if (pv_seen >= 200 && cons_sent < con_target) begin
        con_valid_in = 1'b1;
        cons_sent++;
        if (cons_sent % 4 == 0 && maxs_sent < max_target) begin
          max_valid_in = 1'b1;
          maxs_sent++;
        end
      end
    end
  end

  task automatic start_frame(input int ct, input int mt);
    con_target = ct;
    max_target = mt;
    frame_id++;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 4000 && done_cnt == 0; i++) @(negedge clock);
    if (done_cnt == 0) chk({tag, "_done_timeout"}, 0, 1);
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_addr(input int a, input string tag);
    int i;
    for (i = 0; i < 2000 && !(mem_rd_en && int'(mem_addr) == a); i++) @(negedge clock);
    if (!(mem_rd_en && int'(mem_addr) == a)) chk({tag, "_addr_timeout"}, 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pv", pixel_valid, 0);
    chk("rst_con", con_count, 0);
    chk("rst_max", max_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    @(negedge clock);

    // Normal frame, last con and max valids land together in DRAIN.
    start_frame(676, 169);
    wait_done("norm");
    chk("norm_reads", rd_cnt, 784);
    chk("norm_addr_bad", addr_bad, 0);
    chk("norm_pv_bad", pv_bad, 0);
    chk("norm_pix_bad", pix_bad, 0);
    chk("norm_done_cnt", done_cnt, 1);
    chk("norm_error", error, 0);
    chk("norm_con", con_count, 676);
    chk("norm_max", max_count, 169);
    chk("norm_pause_cyc", pause_cyc, 0);
    chk("norm_busy_after", busy, 0);

    // Pause for five cycles with address 100 pending.
    start_frame(676, 169);
    wait_addr(100, "pause");
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("pause_rd_en", mem_rd_en, 0);
      chk("pause_addr", mem_addr, 100);
      @(negedge clock);
    end
    pause = 1'b0;
    #1;
    chk("pause_resume_rd", mem_rd_en, 1);
    chk("pause_resume_addr", mem_addr, 100);
    wait_done("pause");
    chk("pause_reads", rd_cnt, 784);
    chk("pause_cycles", pause_cyc, 5);
    chk("pause_addr_bad", addr_bad, 0);
    chk("pause_done_cnt", done_cnt, 1);
    chk("pause_error", error, 0);

    // Start pulsed mid-frame must not disturb anything.
    start_frame(676, 169);
    wait_addr(400, "busy_start");
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("busy_start");
    chk("bstart_reads", rd_cnt, 784);
    chk("bstart_addr_bad", addr_bad, 0);
    chk("bstart_con", con_count, 676);
    chk("bstart_max", max_count, 169);
    chk("bstart_done_cnt", done_cnt, 1);
    chk("bstart_error", error, 0);

    // Pipeline short one con valid: 784 feed + 1024 drain cycles, then error.
    start_frame(675, 169);
    wait_done("tmo");
    chk("tmo_error", error, 1);
    chk("tmo_con", con_count, 675);
    chk("tmo_busy_cyc", busy_cyc, 1808);
    chk("tmo_done_cnt", done_cnt, 1);
    chk("tmo_reads", rd_cnt, 784);

    // One con valid too many while still draining.
    start_frame(677, 168);
    for (int i = 0; i < 2000 && cons_sent < 677; i++) @(negedge clock);
    chk("ovf_sent", cons_sent, 677);
    repeat (2) @(negedge clock);
    chk("ovf_error", error, 1);
    chk("ovf_busy", busy, 1);
    chk("ovf_con", con_count, 676);
    wait_done("ovf");
    chk("ovf_con_hold", con_count, 676);
    chk("ovf_error_hold", error, 1);
    chk("ovf_done_cnt", done_cnt, 1);

    // Reset mid-FEED at address 300, then a clean restart.
    start_frame(676, 169);
    wait_addr(300, "mrst");
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mrst_rd_en", mem_rd_en, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_pv", pixel_valid, 0);
    chk("mrst_con", con_count, 0);
    chk("mrst_max", max_count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_error", error, 0);
    @(negedge clock);
    chk("mrst_idle_rd_en", mem_rd_en, 0);
    chk("mrst_idle_pv", pixel_valid, 0);
    start_frame(676, 169);
    wait_done("restart");
    chk("restart_reads", rd_cnt, 784);
    chk("restart_addr_bad", addr_bad, 0);
    chk("restart_pv_bad", pv_bad, 0);
    chk("restart_con", con_count, 676);
    chk("restart_error", error, 0);

    // Reset wins over start on the same edge.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    chk("rprio_busy", busy, 0);
    chk("rprio_rd_en", mem_rd_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
